// File: rtl/ebi_master.sv
// -----------------------------------------------------------------------------
// ebi_master
//
// Asynchronous-SRAM style external bus master for a 16-bit data bus. A single
// request starts one read or write cycle made of three timed phases:
//   SETUP  : chip select low, address stable, no strobe
//   STROBE : chip select low, rd or wr strobe low
//   HOLD   : chip select low, strobe released
// A read adds one TURN cycle after HOLD. This keeps the next transaction from
// driving the shared data bus while the external device may still drive it.
//
// Parameters
//   ADDR_W  external address width, in 16-bit words
//   SETUP   cycles with cs low before the strobe  (values < 1 behave as 1)
//   STROBE  cycles with rd/wr low                 (values < 1 behave as 1)
//   HOLD    cycles with cs low after the strobe   (values < 1 behave as 1)
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active low
//   req            start a transaction (sampled only while idle)
//   req_wr         1 = write, 0 = read
//   req_addr       word address
//   req_wdata      write data
//   busy           transaction or read turnaround in progress
//   done           one-cycle completion pulse
//   rdata          read data, valid from the done pulse until the next read
//   ebi_addr       external address
//   ebi_data_out   external write data
//   ebi_data_oe    enable for the top-level data bus tristate driver
//   ebi_data_in    external read data
//   ebi_cs         chip select, active low
//   ebi_rd         read strobe, active low
//   ebi_wr         write strobe, active low
// -----------------------------------------------------------------------------
module ebi_master #(
    parameter int ADDR_W = 19,
    parameter int SETUP  = 1,
    parameter int STROBE = 3,
    parameter int HOLD   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       rdata,
    output logic [ADDR_W-1:0] ebi_addr,
    output logic [15:0]       ebi_data_out,
    output logic              ebi_data_oe,
    input  logic [15:0]       ebi_data_in,
    output logic              ebi_cs,
    output logic              ebi_rd,
    output logic              ebi_wr
);

    // Phase lengths after clamping to a minimum of one cycle.
    localparam int P_SETUP  = (SETUP  < 1) ? 1 : SETUP;
    localparam int P_STROBE = (STROBE < 1) ? 1 : STROBE;
    localparam int P_HOLD   = (HOLD   < 1) ? 1 : HOLD;

    localparam int P_MAX_SS = (P_SETUP > P_STROBE) ? P_SETUP : P_STROBE;
    localparam int P_MAX    = (P_MAX_SS > P_HOLD) ? P_MAX_SS : P_HOLD;

    // Wide enough to hold the longest phase length, so no phase can wrap.
    localparam int CNT_W = $clog2(P_MAX + 1);

    // The counter is loaded with (length - 1) and the phase ends at zero.
    localparam logic [CNT_W-1:0] C_SETUP  = CNT_W'(P_SETUP  - 1);
    localparam logic [CNT_W-1:0] C_STROBE = CNT_W'(P_STROBE - 1);
    localparam logic [CNT_W-1:0] C_HOLD   = CNT_W'(P_HOLD   - 1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_TURN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic [15:0]         r_rdata;
    logic                r_done;

    logic                w_phase_end;
    logic                w_accept;
    logic                w_capture;
    logic                w_done_nxt;
    logic                w_cs_active;

    assign w_phase_end = (r_cnt == '0);

    // -------------------------------------------------------------------------
    // Next-state and phase counter
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Also reached in a write's done cycle, so a request there is
                // taken without a gap.
                if (req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = C_SETUP;
                end
            end

            ST_SETUP: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = C_STROBE;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end

            ST_STROBE: begin
                if (w_phase_end) begin
                    // Sample read data in the last strobe cycle, while the
                    // device is still being strobed.
                    w_capture   = ~r_wr;
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = C_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end

            ST_HOLD: begin
                if (w_phase_end) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = r_wr ? ST_IDLE : ST_TURN;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end

            ST_TURN: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counter and latched transaction registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_wr    <= req_wr;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_capture) begin
                r_rdata <= ebi_data_in;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from registered state only, so reset forces the bus
    // inactive immediately without waiting for a clock edge.
    // -------------------------------------------------------------------------
    assign w_cs_active = (r_state == ST_SETUP) || (r_state == ST_STROBE) ||
                         (r_state == ST_HOLD);

    assign ebi_cs       = ~w_cs_active;
    assign ebi_rd       = ~((r_state == ST_STROBE) && !r_wr);
    assign ebi_wr       = ~((r_state == ST_STROBE) &&  r_wr);
    assign ebi_data_oe  = w_cs_active & r_wr;
    assign ebi_addr     = r_addr;
    assign ebi_data_out = r_wdata;
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign rdata        = r_rdata;

endmodule

// File: tb/tb_ebi_master.sv
// -----------------------------------------------------------------------------
// tb_ebi_master
//
// Self-checking bench for ebi_master. Two instances are built: one with the
// default timing (1/3/1) and one with SETUP=0, STROBE=5, HOLD=2. Expected bus
// waveforms are computed per cycle from the phase lengths relative to the
// acceptance edge, and read data is tracked by a simple per-instance model.
// -----------------------------------------------------------------------------
module tb_ebi_master;

    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a, req_b;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [15:0]   req_wdata;
    logic [15:0]   data_in;

    logic          busy_a, done_a, oe_a, cs_a, rd_a, wr_a;
    logic [15:0]   rdata_a, dout_a;
    logic [AW-1:0] addr_a;
    logic          busy_b, done_b, oe_b, cs_b, rd_b, wr_b;
    logic [15:0]   rdata_b, dout_b;
    logic [AW-1:0] addr_b;

    // Observed signals of the instance selected by sel.
    int            sel;
    logic          o_busy, o_done, o_oe, o_cs, o_rd, o_wr;
    logic [15:0]   o_rdata, o_dout;
    logic [AW-1:0] o_addr;

    int            errors = 0;
    int            checks = 0;
    logic [15:0]   model_rdata [2];

    always #5 clk = ~clk;

    ebi_master #(.ADDR_W(AW)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy_a), .done(done_a), .rdata(rdata_a),
        .ebi_addr(addr_a), .ebi_data_out(dout_a), .ebi_data_oe(oe_a),
        .ebi_data_in(data_in), .ebi_cs(cs_a), .ebi_rd(rd_a), .ebi_wr(wr_a)
    );

    ebi_master #(.ADDR_W(AW), .SETUP(0), .STROBE(5), .HOLD(2)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy_b), .done(done_b), .rdata(rdata_b),
        .ebi_addr(addr_b), .ebi_data_out(dout_b), .ebi_data_oe(oe_b),
        .ebi_data_in(data_in), .ebi_cs(cs_b), .ebi_rd(rd_b), .ebi_wr(wr_b)
    );

    always_comb begin
        o_busy  = busy_a;  o_done = done_a; o_oe = oe_a;  o_cs = cs_a;
        o_rd    = rd_a;    o_wr   = wr_a;   o_rdata = rdata_a;
        o_dout  = dout_a;  o_addr = addr_a;
        if (sel == 1) begin
            o_busy  = busy_b;  o_done = done_b; o_oe = oe_b;  o_cs = cs_b;
            o_rd    = rd_b;    o_wr   = wr_b;   o_rdata = rdata_b;
            o_dout  = dout_b;  o_addr = addr_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int s, input logic v);
        if (s == 0) req_a = v;
        else        req_b = v;
    endtask

    // One transaction on instance s, checked every cycle from acceptance
    // until the instance is idle again. noise: 0 none, 1 random, 2 every
    // busy cycle -- spurious requests with junk fields that must be ignored.
    task automatic run_txn(input int s, input logic wr, input logic [AW-1:0] addr,
                           input logic [15:0] wd, input logic [15:0] rv,
                           input int noise);
        int s_len, p_len, h_len, l_len, last;
        logic [15:0] old_rd;
        bit cs_low, stb;
        s_len  = 1;
        p_len  = (s == 0) ? 3 : 5;
        h_len  = (s == 0) ? 1 : 2;
        l_len  = s_len + p_len + h_len;
        last   = wr ? l_len + 1 : l_len + 2;
        old_rd = model_rdata[s];
        sel    = s;

        @(posedge clk); #1;
        set_req(s, 1'b1);
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        data_in   = ~rv;

        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            set_req(s, 1'b0);
            if (c >= 2 && c <= l_len &&
                (noise == 2 || (noise == 1 && $urandom_range(1, 0) == 1))) begin
                set_req(s, 1'b1);
                req_wr    = ~wr;
                req_addr  = AW'($urandom);
                req_wdata = 16'($urandom);
            end
            data_in = (c == s_len + p_len) ? rv : ~rv;
            @(negedge clk);
            cs_low = (c >= 1) && (c <= l_len);
            stb    = (c >= s_len + 1) && (c <= s_len + p_len);
            check($sformatf("cs[%0d]@%0d", s, c), 32'(o_cs), 32'(!cs_low));
            check($sformatf("rd[%0d]@%0d", s, c), 32'(o_rd), 32'(!(stb && !wr)));
            check($sformatf("wr[%0d]@%0d", s, c), 32'(o_wr), 32'(!(stb && wr)));
            check($sformatf("oe[%0d]@%0d", s, c), 32'(o_oe), 32'(cs_low && wr));
            check($sformatf("busy[%0d]@%0d", s, c), 32'(o_busy),
                  32'(cs_low || (!wr && c == l_len + 1)));
            check($sformatf("done[%0d]@%0d", s, c), 32'(o_done), 32'(c == l_len + 1));
            check($sformatf("rdata[%0d]@%0d", s, c), 32'(o_rdata),
                  32'((!wr && c > s_len + p_len) ? rv : old_rd));
            if (cs_low) begin
                check($sformatf("addr[%0d]@%0d", s, c), 32'(o_addr), 32'(addr));
            end
            if (cs_low && wr) begin
                check($sformatf("dout[%0d]@%0d", s, c), 32'(o_dout), 32'(wd));
            end
        end
        set_req(s, 1'b0);
        if (!wr) model_rdata[s] = rv;
    endtask

    // Bounded wait for instance A to return to idle with no done pending.
    task automatic wait_idle_a(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (!busy_a && !done_a) ok = 1'b1;
        end
        check({tag, "_idle_timeout"}, 32'(ok), 32'd1);
    endtask

    initial begin
        rst       = 1'b0;
        req_a     = 1'b0;
        req_b     = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        data_in   = '0;
        sel       = 0;
        model_rdata[0] = '0;
        model_rdata[1] = '0;

        // Reset values.
        #12;
        check("rst_cs",    32'(cs_a),    32'd1);
        check("rst_rd",    32'(rd_a),    32'd1);
        check("rst_wr",    32'(wr_a),    32'd1);
        check("rst_oe",    32'(oe_a),    32'd0);
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_done",  32'(done_a),  32'd0);
        check("rst_rdata", 32'(rdata_a), 32'd0);
        check("rst_addr",  32'(addr_a),  32'd0);
        check("rst_dout",  32'(dout_a),  32'd0);
        check("rst_cs_b",  32'(cs_b),    32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Directed write and read with the default timing.
        run_txn(0, 1'b1, 19'h12345, 16'hBEEF, 16'h0000, 0);
        run_txn(0, 1'b0, 19'h00042, 16'h0000, 16'hA5A5, 0);
        // Spurious requests in every busy cycle.
        run_txn(0, 1'b1, 19'h00100, 16'h1234, 16'h0000, 2);
        run_txn(0, 1'b0, 19'h7FFFF, 16'h0000, 16'h5A5A, 2);

        // Write, then a read requested in the write's done cycle.
        sel = 0;
        @(posedge clk); #1;
        req_a = 1'b1; req_wr = 1'b1; req_addr = 19'h00001; req_wdata = 16'h1111;
        data_in = 16'h7E7E;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            req_a = (c == 6);
            if (c == 6) begin
                req_wr = 1'b0; req_addr = 19'h00002;
            end
            @(negedge clk);
        end
        check("b2b_done", 32'(done_a), 32'd1);
        check("b2b_busy", 32'(busy_a), 32'd0);
        @(posedge clk); #1;
        req_a = 1'b0;
        @(negedge clk);
        check("b2b_cs",   32'(cs_a),   32'd0);
        check("b2b_busy1", 32'(busy_a), 32'd1);
        check("b2b_oe",   32'(oe_a),   32'd0);
        check("b2b_addr", 32'(addr_a), 32'h00002);
        wait_idle_a("b2b");
        model_rdata[0] = 16'h7E7E;
        check("b2b_rdata", 32'(rdata_a), 32'h7E7E);

        // Read, then a write request held high through the read.
        @(posedge clk); #1;
        req_a = 1'b1; req_wr = 1'b0; req_addr = 19'h00003; data_in = 16'h3C3C;
        @(posedge clk); #1;
        req_wr = 1'b1; req_addr = 19'h00004; req_wdata = 16'h5555;
        for (int c = 2; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 8) req_a = 1'b0;
            @(negedge clk);
            check($sformatf("turn_cs@%0d", c), 32'(cs_a),
                  32'(!((c <= 5) || (c == 8))));
            check($sformatf("turn_oe@%0d", c), 32'(oe_a), 32'(c == 8));
            if (c == 6) check("turn_rdata", 32'(rdata_a), 32'h3C3C);
        end
        model_rdata[0] = 16'h3C3C;
        wait_idle_a("turn");

        // Reset in the middle of a write.
        @(posedge clk); #1;
        req_a = 1'b1; req_wr = 1'b1; req_addr = 19'h0ABCD; req_wdata = 16'hCAFE;
        @(posedge clk); #1;
        req_a = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("mid_rst_cs",    32'(cs_a),    32'd1);
        check("mid_rst_wr",    32'(wr_a),    32'd1);
        check("mid_rst_oe",    32'(oe_a),    32'd0);
        check("mid_rst_busy",  32'(busy_a),  32'd0);
        check("mid_rst_done",  32'(done_a),  32'd0);
        check("mid_rst_addr",  32'(addr_a),  32'd0);
        check("mid_rst_rdata", 32'(rdata_a), 32'd0);
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("post_rst_done@%0d", c), 32'(done_a), 32'd0);
            check($sformatf("post_rst_cs@%0d", c), 32'(cs_a), 32'd1);
        end
        run_txn(0, 1'b0, 19'h01234, 16'h0000, 16'h9669, 0);

        // Randomized transactions on the default build.
        for (int i = 0; i < 30; i++) begin
            run_txn(0, 1'($urandom), AW'($urandom), 16'($urandom),
                    16'($urandom), 1);
        end

        // Clamped SETUP=0, STROBE=5, HOLD=2 build.
        run_txn(1, 1'b1, 19'h12345, 16'hBEEF, 16'h0000, 0);
        run_txn(1, 1'b0, 19'h00042, 16'h0000, 16'hA5A5, 2);
        for (int i = 0; i < 10; i++) begin
            run_txn(1, 1'($urandom), AW'($urandom), 16'($urandom),
                    16'($urandom), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
